// File: rtl/hsn_pkg.sv
// Shared types and header helpers for the block-sync slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hsn_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    function automatic logic hdr_valid(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/hsn_slice_extract.sv
// Registers the gearbox window slice, then muxes header/payload at the search offset.
// Latency: 1 cycle register, evaluation outputs combinational from it.
// Backpressure: none; buffer_dv gaps simply leave ev_dv low.
module hsn_slice_extract
    import hsn_pkg::*;
#(
    parameter int GBOX_W  = 194,
    parameter int CNT_W   = 6,
    parameter int FRAME_W = 66,
    parameter int MAX_POS = 65,
    parameter int POS_W   = 7
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [GBOX_W-1:0]  gbox_buffer,
    input  logic [CNT_W-1:0]   gbox_cnt,
    input  logic               buffer_dv,
    input  logic [POS_W-1:0]   offset_pos,
    output logic               ev_dv,
    output logic [1:0]         ev_hdr,
    output logic [FRAME_W-3:0] ev_data
);

    localparam int SLICE_W = FRAME_W + MAX_POS;
    localparam int GIDX_W  = $clog2(GBOX_W);
    localparam int SIDX_W  = $clog2(SLICE_W);

    logic [SLICE_W-1:0] slice_q;
    logic               dv_q;
    logic [GIDX_W-1:0]  gbox_base;
    logic [SIDX_W-1:0]  hdr_base;
    logic [SIDX_W-1:0]  data_base;

    // Index arithmetic kept at select width so the muxes stay exactly sized.
    assign gbox_base = GIDX_W'(GBOX_W - 1) - GIDX_W'(gbox_cnt);
    assign hdr_base  = SIDX_W'(SLICE_W - 1) - SIDX_W'(offset_pos);
    assign data_base = hdr_base - SIDX_W'(2);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            slice_q <= '0;
            dv_q    <= 1'b0;
        end else begin
            dv_q <= buffer_dv;
            if (buffer_dv) begin
                slice_q <= gbox_buffer[gbox_base -: SLICE_W];
            end
        end
    end

    assign ev_dv   = dv_q;
    assign ev_hdr  = slice_q[hdr_base -: 2];
    assign ev_data = slice_q[data_base -: FRAME_W-2];

endmodule

// File: rtl/hsn_block_sync.sv
// Sync-header search/lock over all offsets with windowed loss-of-lock; optional HSN_HDR_STATS_EN error counter.
// Latency: buffer_dv at cycle N -> frame_dv_o and state/offset update at N+2.
// Backpressure: none; accepts buffer_dv every cycle, idle cycles count no frame.
module hsn_block_sync
    import hsn_pkg::*;
#(
    parameter int GBOX_W   = 194,
    parameter int CNT_W    = 6,
    parameter int FRAME_W  = 66,
    parameter int MIN_POS  = 0,
    parameter int MAX_POS  = 65,
    parameter int POS_W    = 7,
    parameter int LOCK_CNT = 64,
    parameter int WIN_LEN  = 1024,
    parameter int BAD_MAX  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [GBOX_W-1:0]  gbox_buffer,
    input  logic [CNT_W-1:0]   gbox_cnt,
    input  logic               buffer_dv,
    input  logic               force_resync_i,
    output logic               is_synced,
    output logic [POS_W-1:0]   offset_pos,
    output logic               frame_dv_o,
    output logic [1:0]         frame_hdr_o,
    output logic [FRAME_W-3:0] frame_data_o,
    output logic               lock_lost_o,
    output logic [15:0]        slip_cnt_o,
    output logic [15:0]        hdr_err_cnt_o
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WIN_LEN + 1);
    localparam int BAD_W  = $clog2(BAD_MAX + 1);

    sync_state_t        state_q, state_d;
    logic [POS_W-1:0]   offset_q;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [WIN_W-1:0]   win_q, win_d, win_inc;
    logic [BAD_W-1:0]   bad_q, bad_d, bad_inc;
    logic [15:0]        slip_q;
    logic               ev_dv, ev_good;
    logic [1:0]         ev_hdr;
    logic [FRAME_W-3:0] ev_data;
    logic               do_slip, lost, take;

    hsn_slice_extract #(
        .GBOX_W  (GBOX_W),
        .CNT_W   (CNT_W),
        .FRAME_W (FRAME_W),
        .MAX_POS (MAX_POS),
        .POS_W   (POS_W)
    ) u_extract (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .gbox_buffer (gbox_buffer),
        .gbox_cnt    (gbox_cnt),
        .buffer_dv   (buffer_dv),
        .offset_pos  (offset_q),
        .ev_dv       (ev_dv),
        .ev_hdr      (ev_hdr),
        .ev_data     (ev_data)
    );

    assign ev_good = hdr_valid(ev_hdr);
    assign win_inc = win_q + 1'b1;
    assign bad_inc = bad_q + BAD_W'(!ev_good);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        win_d   = win_q;
        bad_d   = bad_q;
        do_slip = 1'b0;
        lost    = 1'b0;
        take    = 1'b0;
        if (force_resync_i) begin
            state_d = HUNT;
            good_d  = '0;
            win_d   = '0;
            bad_d   = '0;
        end else if (ev_dv) begin
            unique case (state_q)
                HUNT: begin
                    if (ev_good) begin
                        state_d = VERIFY;
                        good_d  = GOOD_W'(1);
                    end else begin
                        do_slip = 1'b1;
                    end
                end
                VERIFY: begin
                    if (ev_good) begin
                        good_d = good_q + 1'b1;
                        if (good_d == GOOD_W'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            win_d   = '0;
                            bad_d   = '0;
                        end
                    end else begin
                        state_d = HUNT;
                        do_slip = 1'b1;
                    end
                end
                LOCKED: begin
                    // Loss is checked first so it wins over a window rollover.
                    if (bad_inc == BAD_W'(BAD_MAX)) begin
                        state_d = HUNT;
                        lost    = 1'b1;
                        do_slip = 1'b1;
                    end else begin
                        take = 1'b1;
                        if (win_inc == WIN_W'(WIN_LEN)) begin
                            win_d = '0;
                            bad_d = '0;
                        end else begin
                            win_d = win_inc;
                            bad_d = bad_inc;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
            if (do_slip) begin
                good_d = '0;
                win_d  = '0;
                bad_d  = '0;
            end
        end
    end

    always_comb begin
        is_synced = (state_q == LOCKED);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            offset_q     <= POS_W'(MIN_POS);
            good_q       <= '0;
            win_q        <= '0;
            bad_q        <= '0;
            slip_q       <= '0;
            lock_lost_o  <= 1'b0;
            frame_dv_o   <= 1'b0;
            frame_hdr_o  <= '0;
            frame_data_o <= '0;
        end else begin
            good_q      <= good_d;
            win_q       <= win_d;
            bad_q       <= bad_d;
            lock_lost_o <= lost;
            frame_dv_o  <= take;
            if (take) begin
                frame_hdr_o  <= ev_hdr;
                frame_data_o <= ev_data;
            end
            if (do_slip) begin
                offset_q <= (offset_q == POS_W'(MAX_POS)) ? POS_W'(MIN_POS) : offset_q + 1'b1;
                if (slip_q != 16'hFFFF) begin
                    slip_q <= slip_q + 1'b1;
                end
            end
        end
    end

    assign offset_pos = offset_q;
    assign slip_cnt_o = slip_q;

`ifdef HSN_HDR_STATS_EN
    logic [15:0] hdr_err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hdr_err_q <= '0;
        end else if (force_resync_i) begin
            hdr_err_q <= '0;
        end else if (ev_dv && !ev_good && hdr_err_q != 16'hFFFF) begin
            hdr_err_q <= hdr_err_q + 1'b1;
        end
    end

    assign hdr_err_cnt_o = hdr_err_q;
`else
    assign hdr_err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hsn_block_sync.sv
// Directed bench for hsn_block_sync: table-driven frame extraction plus lock/loss/resync sequences.
module tb_hsn_block_sync;

    logic         clk;
    logic         rst_n;
    logic [193:0] gbox_buffer;
    logic [5:0]   gbox_cnt;
    logic         buffer_dv;
    logic         force_resync;
    logic         is_synced;
    logic [6:0]   offset_pos;
    logic         frame_dv_o;
    logic [1:0]   frame_hdr_o;
    logic [63:0]  frame_data_o;
    logic         lock_lost_o;
    logic [15:0]  slip_cnt_o;
    logic [15:0]  hdr_err_cnt_o;

    int n_cmp = 0;
    int n_err = 0;
    int n_frames = 0;
    int n_lost = 0;
    int fcnt = 0;

    hsn_block_sync dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .gbox_buffer    (gbox_buffer),
        .gbox_cnt       (gbox_cnt),
        .buffer_dv      (buffer_dv),
        .force_resync_i (force_resync),
        .is_synced      (is_synced),
        .offset_pos     (offset_pos),
        .frame_dv_o     (frame_dv_o),
        .frame_hdr_o    (frame_hdr_o),
        .frame_data_o   (frame_data_o),
        .lock_lost_o    (lock_lost_o),
        .slip_cnt_o     (slip_cnt_o),
        .hdr_err_cnt_o  (hdr_err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (frame_dv_o)  n_frames++;
        if (lock_lost_o) n_lost++;
    end

    typedef struct {
        logic [1:0]  hdr;
        logic [63:0] pl;
        logic        exp_dv;
        logic [1:0]  exp_hdr;
        logic [63:0] exp_data;
        logic        exp_sync;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Header h at offset t; bits above it repeat h[1] so every lower offset sees 00 or 11.
    function automatic logic [130:0] mk_slice(input int t, input logic [1:0] h, input logic [63:0] pl);
        logic [130:0] s;
        s = h[1] ? {131{1'b1}} : {131{1'b0}};
        s[130-t] = h[1];
        s[129-t] = h[0];
        s[128-t -: 64] = pl;
        return s;
    endfunction

    task automatic drive(input logic [130:0] s);
        logic [62:0]  junk;
        logic [193:0] ones;
        @(negedge clk);
        junk         = 63'({$urandom, $urandom});
        ones         = {194{1'b1}};
        gbox_cnt     = 6'(fcnt % 64);
        gbox_buffer  = ({s, junk} >> gbox_cnt) | ~(ones >> gbox_cnt);
        buffer_dv    = 1'b1;
        force_resync = 1'b0;
        fcnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            buffer_dv    = 1'b0;
            force_resync = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        buffer_dv    = 1'b0;
        force_resync = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [63:0] PL_A = 64'hA5A5_1234_5678_9ABC;

    task automatic lock_at(input int t);
        do_reset();
        for (int i = 0; i < t + 64; i++) drive(mk_slice(t, 2'b01, PL_A));
        idle(2);
    endtask

    vec_t vecs[6];
    int   f0, l0;

    initial begin
        rst_n        = 1'b0;
        buffer_dv    = 1'b0;
        force_resync = 1'b0;
        gbox_buffer  = '0;
        gbox_cnt     = '0;

        vecs[0] = '{2'b01, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 2'b01, 64'hDEAD_BEEF_0BAD_F00D, 1'b1};
        vecs[1] = '{2'b10, 64'h0123_4567_89AB_CDEF, 1'b1, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b1};
        vecs[2] = '{2'b00, 64'hFFFF_0000_FFFF_0000, 1'b1, 2'b00, 64'hFFFF_0000_FFFF_0000, 1'b1};
        vecs[3] = '{2'b11, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 2'b11, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1};
        vecs[4] = '{2'b01, 64'h8000_0000_0000_0001, 1'b1, 2'b01, 64'h8000_0000_0000_0001, 1'b1};
        vecs[5] = '{2'b10, 64'h7FFF_FFFF_FFFF_FFFE, 1'b1, 2'b10, 64'h7FFF_FFFF_FFFF_FFFE, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_synced", is_synced, 0);
        check("rst_offset", offset_pos, 0);
        check("rst_frame_dv", frame_dv_o, 0);
        check("rst_hdr", frame_hdr_o, 0);
        check("rst_data", frame_data_o, 0);
        check("rst_lost", lock_lost_o, 0);
        check("rst_slip", slip_cnt_o, 0);
        check("rst_hdr_err", hdr_err_cnt_o, 0);
        rst_n = 1'b1;

        // Header at offset 5: 5 slips then 64 good frames lock
        do_reset();
        for (int i = 0; i < 68; i++) drive(mk_slice(5, 2'b01, PL_A));
        idle(2);
        check("off5_not_yet_synced", is_synced, 0);
        check("off5_offset_pre", offset_pos, 5);
        drive(mk_slice(5, 2'b01, PL_A));
        idle(2);
        check("off5_synced", is_synced, 1);
        check("off5_offset", offset_pos, 5);
        check("off5_slips", slip_cnt_o, 5);
        check("off5_no_frames_prelock", n_frames, 0);
`ifdef HSN_HDR_STATS_EN
        check("off5_hdr_err", hdr_err_cnt_o, 5);
`else
        check("off5_hdr_err_tied", hdr_err_cnt_o, 0);
`endif

        // Two-cycle latency of frame_dv_o
        f0 = n_frames;
        drive(mk_slice(5, 2'b10, PL_A));
        idle(1);
        check("lat_cycle1", frame_dv_o, 0);
        idle(1);
        check("lat_cycle2", frame_dv_o, 1);
        check("lat_data", frame_data_o, PL_A);
        idle(1);
        check("lat_pulse_end", frame_dv_o, 0);
        check("lat_one_pulse", n_frames - f0, 1);

        // Table-driven extraction at offset 5 with varying window index
        foreach (vecs[k]) begin
            drive(mk_slice(5, vecs[k].hdr, vecs[k].pl));
            idle(2);
            check($sformatf("vec%0d_dv", k), frame_dv_o, vecs[k].exp_dv);
            check($sformatf("vec%0d_hdr", k), frame_hdr_o, vecs[k].exp_hdr);
            check($sformatf("vec%0d_data", k), frame_data_o, vecs[k].exp_data);
            check($sformatf("vec%0d_sync", k), is_synced, vecs[k].exp_sync);
        end

        // 16 bad headers inside one window drop lock
        lock_at(5);
        f0 = n_frames;
        l0 = n_lost;
        for (int i = 0; i < 25; i++)
            drive(mk_slice(5, (i < 15) ? 2'b00 : 2'b01, PL_A));
        idle(2);
        check("loss15_synced", is_synced, 1);
        check("loss15_no_lost", n_lost - l0, 0);
        drive(mk_slice(5, 2'b11, PL_A));
        idle(2);
        check("loss16_lost_pulses", n_lost - l0, 1);
        check("loss16_synced", is_synced, 0);
        check("loss16_offset", offset_pos, 6);
        check("loss16_slips", slip_cnt_o, 6);
        check("loss16_frames", n_frames - f0, 25);

        // 15 bad per window across 3 windows stays locked
        lock_at(5);
        l0 = n_lost;
        for (int i = 0; i < 3072; i++)
            drive(mk_slice(5, ((i % 1024) >= 500 && (i % 1024) < 515) ? 2'b00 : 2'b01, PL_A));
        idle(2);
        check("win3_synced", is_synced, 1);
        check("win3_no_lost", n_lost - l0, 0);
        check("win3_slips", slip_cnt_o, 5);

        // 16th bad on the window's last frame: loss wins
        lock_at(5);
        f0 = n_frames;
        l0 = n_lost;
        for (int i = 0; i < 1024; i++)
            drive(mk_slice(5, (i >= 1008) ? 2'b00 : 2'b10, PL_A));
        idle(2);
        check("prio_lost", n_lost - l0, 1);
        check("prio_synced", is_synced, 0);
        check("prio_offset", offset_pos, 6);
        check("prio_frames", n_frames - f0, 1023);

        // force_resync while locked at 12, overriding an evaluated frame
        lock_at(12);
        f0 = n_frames;
        l0 = n_lost;
        drive(mk_slice(12, 2'b01, PL_A));
        @(negedge clk);
        buffer_dv    = 1'b0;
        force_resync = 1'b1;
        @(negedge clk);
        force_resync = 1'b0;
        check("rs_synced", is_synced, 0);
        check("rs_offset", offset_pos, 12);
        check("rs_slips", slip_cnt_o, 12);
        check("rs_no_lost", n_lost - l0, 0);
        check("rs_frame_overridden", n_frames - f0, 0);
        for (int i = 0; i < 63; i++) drive(mk_slice(12, 2'b01, PL_A));
        idle(2);
        check("rs_63_not_synced", is_synced, 0);
        drive(mk_slice(12, 2'b01, PL_A));
        idle(2);
        check("rs_relock", is_synced, 1);
        check("rs_relock_offset", offset_pos, 12);

        // Offset wraps 65 -> 0 and locks at 0
        do_reset();
        for (int i = 0; i < 65; i++) drive('0);
        idle(2);
        check("wrap_at65", offset_pos, 65);
        check("wrap_slips65", slip_cnt_o, 65);
        drive(mk_slice(0, 2'b01, 64'h0123_4567_89AB_CDEE));
        idle(2);
        check("wrap_to0", offset_pos, 0);
        check("wrap_slips66", slip_cnt_o, 66);
        for (int i = 0; i < 64; i++) drive(mk_slice(0, 2'b01, 64'h0123_4567_89AB_CDEE));
        idle(2);
        check("wrap_locked", is_synced, 1);
        check("wrap_lock_offset", offset_pos, 0);

        // Async reset mid-VERIFY
        do_reset();
        for (int i = 0; i < 15; i++) drive(mk_slice(5, 2'b01, PL_A));
        idle(2);
        check("mid_offset", offset_pos, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_offset", offset_pos, 0);
        check("arst_slips", slip_cnt_o, 0);
        check("arst_synced", is_synced, 0);
        check("arst_hdr_err", hdr_err_cnt_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Header error statistics
        for (int i = 0; i < 3; i++) drive('0);
        idle(2);
`ifdef HSN_HDR_STATS_EN
        check("stats_3_bad", hdr_err_cnt_o, 3);
`else
        check("stats_tied_zero", hdr_err_cnt_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hsn_block_sync.md
Name: hsn_block_sync

Overview:
- Successor to the fixed-offset header-sync top.
- Slices a gearbox buffer at the gearbox window index and searches every bit offset MIN_POS..MAX_POS for a valid 2-bit sync header (01/10).
- Runs a full HUNT/VERIFY/LOCKED state machine with windowed loss-of-lock, and emits aligned header + payload frames.
- Sits between the RX gearbox and the frame descrambler/decoder.

Parameters:
- GBOX_W, 194, gearbox buffer width.
- CNT_W, 6, width of the gearbox window index.
- FRAME_W, 66, frame width including the 2-bit header.
- MIN_POS, 0, lowest offset searched.
- MAX_POS, 65, highest offset searched; MAX_POS-MIN_POS+1 <= FRAME_W.
- POS_W, 7, offset_pos width.
- LOCK_CNT, 64, consecutive good headers required to lock.
- WIN_LEN, 1024, frames per loss-of-lock window.
- BAD_MAX, 16, bad headers within a window that drop lock.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-low
- gbox_buffer  in  GBOX_W  complete gearbox buffer
- gbox_cnt  in  CNT_W  buffer view window index
- buffer_dv  in  1  gbox_buffer/gbox_cnt valid this cycle
- force_resync_i  in  1  synchronous pulse: restart search
- is_synced  out  1  high in LOCKED
- offset_pos  out  POS_W  current search/lock offset
- frame_dv_o  out  1  aligned frame valid (1-cycle pulse)
- frame_hdr_o  out  2  aligned sync header
- frame_data_o  out  FRAME_W-2  aligned payload
- lock_lost_o  out  1  1-cycle pulse on LOCKED->HUNT
- slip_cnt_o  out  16  saturating count of offset slips
- hdr_err_cnt_o  out  16  saturating bad-header count (feature-gated)

Behaviour:
- Slice and extraction:
  - SLICE_W = FRAME_W + MAX_POS.
  - On buffer_dv, register slice = gbox_buffer[GBOX_W-1-gbox_cnt -: SLICE_W] and set dv_q=1; otherwise dv_q=0.
  - Constraint: GBOX_W-SLICE_W >= 2**CNT_W-1. Defaults: 194-131 = 63.
  - Evaluation stage, when dv_q=1 at offset p: hdr = slice[SLICE_W-1-p -: 2], data = slice[SLICE_W-3-p -: FRAME_W-2]; good = (hdr==01 || hdr==10).
- Reset: all outputs 0; offset_pos = MIN_POS; state = HUNT; all counters 0.
- States (transitions only on evaluated frames):
  - HUNT: good -> VERIFY, good_cnt=1. Bad -> slip.
  - VERIFY: good -> good_cnt+1; when it reaches LOCK_CNT -> LOCKED, is_synced=1, win_cnt=bad_cnt=0. Bad -> slip, HUNT.
  - LOCKED: each frame increments win_cnt; bad increments bad_cnt.
    - bad_cnt reaching BAD_MAX -> HUNT, slip, is_synced=0, lock_lost_o=1.
    - Otherwise, win_cnt reaching WIN_LEN -> win_cnt=bad_cnt=0.
    - Loss takes priority when both occur on the same frame.
- Slip: offset_pos+1, wrapping MAX_POS -> MIN_POS. Clears good_cnt, win_cnt and bad_cnt. slip_cnt_o increments, saturating at 16'hFFFF.
- force_resync_i:
  - From any state -> HUNT; counters cleared; offset_pos unchanged; is_synced=0 next cycle.
  - No lock_lost_o pulse and no slip.
  - Overrides a frame evaluated in the same cycle.
- Frame output: frame_dv_o/frame_hdr_o/frame_data_o register every evaluated frame while in LOCKED, including bad-header frames, except the frame that causes loss of lock. Data outputs hold between pulses.
- Latency: buffer_dv at cycle N -> frame_dv_o and state/offset update at N+2.
- Back-to-back buffer_dv every cycle is supported; gaps are ignored (no frame counted).
- is_synced and offset_pos update in the same cycle as the transition.

Optional Feature:
- Macro HSN_HDR_STATS_EN.
- Defined: hdr_err_cnt_o counts every bad header in any state, saturating at 16'hFFFF; cleared by reset and by force_resync_i.
- Undefined: hdr_err_cnt_o tied to 0 and no counter is inferred.
- All other behaviour is identical either way.

Decomposition:
- Package hsn_pkg:
  - enum sync_state_t {HUNT, VERIFY, LOCKED}.
  - Header constants HDR_DATA=2'b01, HDR_CTRL=2'b10.
  - Function hdr_valid().
- Sub-module hsn_slice_extract: registered slice plus offset mux producing hdr/data/dv. The state machine and counters stay in hsn_block_sync.

Test Plan:
- Stream of frames with the true header at offset 5, LOCK_CNT=64 -> after 5 slips, 64 good frames give is_synced=1, offset_pos=5, slip_cnt_o=5; first frame_dv_o 2 cycles later.
- Offset 65 with true alignment at MIN_POS=0 and bad headers at 65 -> offset_pos wraps 65->0 and locks at 0.
- Locked; inject 16 bad headers within 1024 frames -> lock_lost_o single pulse on the 16th, is_synced=0, offset_pos+1. Inject 15 per window -> stays locked across 3 windows.
- Bad header on frame 1024 of a window where it is the 16th bad -> loss wins, no window reset.
- force_resync_i while LOCKED at offset 12 -> HUNT, offset_pos=12, no lock_lost_o pulse; relock after 64 good frames.
- Assert rst_i low mid-VERIFY -> all outputs 0 and offset_pos=MIN_POS immediately; with HSN_HDR_STATS_EN, 3 bad headers -> hdr_err_cnt_o=3.
